// File: rtl/alu.sv
// 4-bit ALU execute stage. A packed operation word {opcode, a, b} is decoded
// combinationally. The result, carry and zero flags are registered on every
// rising clock edge, so results appear exactly one cycle after the word is
// sampled.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] in,
  output logic [3:0]  sum,
  output logic        carry,
  output logic        zero
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_INC = 4'd8
  } opcode_e;

  logic [3:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] shamt;

  assign op    = in[11:8];
  assign a     = in[7:4];
  assign b     = in[3:0];
  assign shamt = b[1:0];

  // Widened intermediates. Bit 4 of each one holds the carry/borrow,
  // or the last bit shifted out of the operand.
  logic [4:0] add_w;
  logic [4:0] sub_w;
  logic [4:0] inc_w;
  logic [4:0] shl_w;
  logic [4:0] shr_w;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign inc_w = {1'b0, a} + 5'd1;
  // For a left shift, a zero guard bit above a catches the last bit out of a[3].
  assign shl_w = {1'b0, a} << shamt;
  // For a right shift, a guard bit below a catches the last bit out of a[0].
  // The result sits in [4:1] and the shifted-out bit lands in [0].
  assign shr_w = {a, 1'b0} >> shamt;

  logic [3:0] res_d;
  logic       carry_d;

  // Opcode decode into next result and carry.
  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    res_d   = 4'h0;
    carry_d = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = add_w[3:0];
        carry_d = add_w[4];
      end
      OP_SUB: begin
        res_d   = sub_w[3:0];
        carry_d = sub_w[4];
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_NOT: res_d = ~a;
      OP_SHL: begin
        res_d   = shl_w[3:0];
        carry_d = shl_w[4];
      end
      OP_SHR: begin
        res_d   = shr_w[4:1];
        carry_d = shr_w[0];
      end
      OP_INC: begin
        res_d   = inc_w[3:0];
        carry_d = inc_w[4];
      end
      default: begin
        res_d   = 4'h0;
        carry_d = 1'b0;
      end
    endcase
  end

  // Output registers: capture the decoded result every cycle, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= 4'h0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      sum   <= res_d;
      carry <= carry_d;
      zero  <= (res_d == 4'h0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written latency
// and reset sequences, and an opcode sweep against an integer reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [11:0] in;
  logic [3:0]  sum;
  logic        carry;
  logic        zero;

  int total = 0;
  int bad   = 0;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .sum   (sum),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] word;
    logic [3:0]  exp_sum;
    logic        exp_carry;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  // Compare the packed {sum, carry, zero} against the expected value.
  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sum=%h carry=%b zero=%b, want sum=%h carry=%b zero=%b",
               name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Reference model in integer arithmetic. Shifts are done one bit at a time.
  function automatic logic [5:0] model(input logic [11:0] w);
    int op;
    int a;
    int b;
    int r;
    int c;
    int n;
    op = int'(w[11:8]);
    a  = int'(w[7:4]);
    b  = int'(w[3:0]);
    r  = 0;
    c  = 0;
    case (op)
      0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin
        r = a;
        n = b % 4;
        for (int i = 0; i < n; i++) begin
          c = (r >> 3) & 1;
          r = (r << 1) & 15;
        end
      end
      7: begin
        r = a;
        n = b % 4;
        for (int i = 0; i < n; i++) begin
          c = r & 1;
          r = r >> 1;
        end
      end
      8: begin r = (a + 1) % 16; c = (a == 15) ? 1 : 0; end
      default: begin r = 0; c = 0; end
    endcase
    return {r[3:0], c[0], (r == 0)};
  endfunction

  task automatic apply(input logic [11:0] w);
    @(negedge clk);
    in = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed vectors with hand-computed results.
    vecs.push_back('{"add_wrap",    12'h097, 4'h0, 1'b1, 1'b1});
    vecs.push_back('{"sub_borrow",  12'h135, 4'hE, 1'b1, 1'b0});
    vecs.push_back('{"inc_wrap",    12'h8F3, 4'h0, 1'b1, 1'b1});
    vecs.push_back('{"and_ca",      12'h2CA, 4'h8, 1'b0, 1'b0});
    vecs.push_back('{"or_ca",       12'h3CA, 4'hE, 1'b0, 1'b0});
    vecs.push_back('{"xor_ca",      12'h4CA, 4'h6, 1'b0, 1'b0});
    vecs.push_back('{"not_ca",      12'h5CA, 4'h3, 1'b0, 1'b0});
    vecs.push_back('{"shl_9_1",     12'h691, 4'h2, 1'b1, 1'b0});
    vecs.push_back('{"shr_9_2",     12'h792, 4'h2, 1'b0, 1'b0});
    vecs.push_back('{"shl_by0",     12'h694, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{"shr_by0",     12'h79C, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{"shl_f_3",     12'h6F3, 4'h8, 1'b1, 1'b0});
    vecs.push_back('{"shr_8_3",     12'h783, 4'h1, 1'b0, 1'b0});
    vecs.push_back('{"add_zero",    12'h000, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{"sub_equal",   12'h155, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{"inc_7",       12'h87A, 4'h8, 1'b0, 1'b0});
    vecs.push_back('{"reserved_f",  12'hFFF, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{"reserved_9",  12'h9AB, 4'h0, 1'b0, 1'b1});

    // Reset held with a live operation word on the input.
    rst_n = 1'b0;
    in    = 12'h0FF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {sum, carry, zero}, 6'b0000_0_0);

    // The first edge after release captures ADD F+F.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture", {sum, carry, zero}, {4'hE, 1'b1, 1'b0});

    // Directed table.
    foreach (vecs[i]) begin
      apply(vecs[i].word);
      check(vecs[i].name, {sum, carry, zero},
            {vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_zero});
    end

    // Latency: a mid-cycle change of in must wait for the next rising edge.
    apply(12'hB55);
    check("reserved_b", {sum, carry, zero}, {4'h0, 1'b0, 1'b1});
    #1;
    in = 12'h011;
    #2;
    check("hold_between_edges", {sum, carry, zero}, {4'h0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("next_edge_update", {sum, carry, zero}, {4'h2, 1'b0, 1'b0});

    // Back-to-back sweep with a mid-sweep asynchronous reset.
    for (int op = 0; op <= 8; op++) begin
      for (int k = 0; k < 10; k++) begin
        logic [11:0] w;
        w = {op[3:0], 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0))};
        apply(w);
        check($sformatf("sweep_op%0d_%0d", op, k), {sum, carry, zero}, model(w));
        if (op == 4 && k == 5) begin
          #1;
          rst_n = 1'b0;
          #1;
          check("async_reset_mid", {sum, carry, zero}, 6'b0000_0_0);
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit arithmetic/logic unit with registered outputs.
- Takes a packed 12-bit operation word (4-bit opcode, 4-bit operand A, 4-bit operand B).
- Produces a 4-bit result plus carry and zero flags, one clock after the operation word is sampled.
- Used as the datapath execute stage; driven by a controller or bench that steps opcodes 0..8 with random operands.

Parameters:
- None. Widths are fixed: opcode 4 bits, operands 4 bits, result 4 bits.

Ports:
- clk    input   1   rising-edge clock
- rst_n  input   1   asynchronous reset, active low
- in     input   12  operation word: in[11:8]=opcode, in[7:4]=a, in[3:0]=b
- sum    output  4   registered result
- carry  output  1   registered carry/borrow flag
- zero   output  1   registered flag, 1 when the computed result is 4'h0

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, sum=4'h0, carry=0 and zero=0, immediately and independent of clk.
- First capture after reset: on the first rising clk edge after rst_n rises, the outputs take the result of the current in.
- Reset mid-operation: any pending result is discarded; no partial state survives.
- Datapath: purely combinational decode of in, captured into the output registers on every rising clk edge. No enable and no handshake.
- Latency: exactly 1 cycle. in changed before edge N appears on the outputs after edge N.
- Back-to-back: a new in every cycle yields a new result every cycle.
- Opcode table (a=in[7:4], b=in[3:0]; all results truncated to 4 bits):
  - 0 ADD: sum=a+b mod 16; carry=bit 4 of the 5-bit sum.
  - 1 SUB: sum=a-b mod 16; carry=1 when a<b (borrow), else 0.
  - 2 AND: a&b; carry=0.
  - 3 OR: a|b; carry=0.
  - 4 XOR: a^b; carry=0.
  - 5 NOT: ~a (b ignored); carry=0.
  - 6 SHL: a<<b[1:0], zero fill; carry=last bit shifted out of a[3] (0 when b[1:0]=0).
  - 7 SHR: logical a>>b[1:0], zero fill; carry=last bit shifted out of a[0] (0 when b[1:0]=0).
  - 8 INC: a+1 mod 16 (b ignored); carry=1 only when a=4'hF.
  - 9..15 reserved: sum=4'h0, carry=0, zero=1.
- Zero flag: zero = (computed 4-bit result == 0), evaluated for every opcode including reserved ones.
- Unknown inputs: X/Z bits on in are not required to be handled. The bench drives only known values.
- No internal state other than the three output registers.

Test Plan:
- Reset: hold rst_n=0 with in=12'h0FF, toggle clk -> sum=0, carry=0, zero=0. Release rst_n, one edge -> sum=4'hE, carry=1, zero=0 (ADD F+F).
- Arithmetic wrap:
  - in={0,4'h9,4'h7} -> sum=0, carry=1, zero=1.
  - in={1,4'h3,4'h5} -> sum=4'hE, carry=1.
  - in={8,4'hF,x} -> sum=0, carry=1, zero=1.
- Logic ops with a=4'hC, b=4'hA:
  - op2 -> 8.
  - op3 -> E.
  - op4 -> 6.
  - op5 -> 3.
  - carry=0 for all four.
- Shifts:
  - in={6,4'h9,4'h1} -> sum=2, carry=1.
  - in={7,4'h9,4'h2} -> sum=2, carry=0.
  - b[1:0]=0 -> sum=a, carry=0.
- Reserved and latency: in={4'hB,4'h5,4'h5} -> sum=0, zero=1. Changing in between edges must not change the outputs until the next rising edge.
- Sweep: opcodes 0..8, 10 random (a,b) pairs each, one per cycle. Compare against the reference model with 1-cycle delay; assert rst_n mid-sweep -> outputs clear asynchronously.
